// File: rtl/sram_cmd_sequencer.sv
// Burst command engine for a single-port synchronous SRAM with a credit-limited read return buffer.
// Optional feature macro: SRAM_SEQ_BOUNDS_CHECK_EN (rejects bursts that would run past the last word).
module sram_cmd_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rnw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int BUF_D  = RD_LAT + 2;
  localparam int PTR_W  = $clog2(BUF_D);
  localparam int CNT_W  = $clog2(2 * BUF_D + 1);
  localparam int BEAT_W = LEN_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cur_addr, cur_addr_next;
  logic [BEAT_W-1:0] beats, beats_next;
  logic              err_next;
  logic              ce_n_next, we_n_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wdata_next;
  logic [RD_LAT-1:0] tag, tag_next;
  logic [DATA_W-1:0] buf_mem [BUF_D];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, outstanding;
  logic              read_in_reg, push, pop, credit_ok, reject;

  // A read sitting in the output register has not reached the SRAM yet but still holds a credit.
  assign read_in_reg = !sram_ce_n && sram_we_n;
  assign push        = tag[RD_LAT-1];
  assign rd_valid    = (count != '0);
  assign pop         = rd_valid && rd_ready;
  assign rd_data     = rd_valid ? buf_mem[rd_ptr] : '0;
  assign cmd_ready   = (state == S_IDLE);
  assign wr_ready    = (state == S_WRITE);
  assign done        = (state == S_DONE);
  assign credit_ok   = (outstanding + count) < CNT_W'(BUF_D);

  always_comb begin
    outstanding = CNT_W'(read_in_reg);
    for (int i = 0; i < RD_LAT; i++) outstanding = outstanding + CNT_W'(tag[i]);
  end

  always_comb begin
    tag_next    = '0;
    tag_next[0] = read_in_reg;
    for (int i = 1; i < RD_LAT; i++) tag_next[i] = tag[i-1];
  end

`ifdef SRAM_SEQ_BOUNDS_CHECK_EN
  localparam int SUM_W = ADDR_W + LEN_W + 1;
  logic [SUM_W-1:0] span_end;
  assign span_end = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign reject   = span_end > SUM_W'((1 << ADDR_W) - 1);
`else
  assign reject = 1'b0;
`endif

  always_comb begin
    state_next    = state;
    cur_addr_next = cur_addr;
    beats_next    = beats;
    err_next      = err;
    ce_n_next     = 1'b1;
    we_n_next     = 1'b1;
    addr_next     = sram_addr;
    wdata_next    = sram_wdata;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cur_addr_next = cmd_addr;
          beats_next    = {1'b0, cmd_len} + BEAT_W'(1);
          err_next      = reject;
          if (reject) state_next = S_DONE;
          else        state_next = cmd_rnw ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          ce_n_next     = 1'b0;
          we_n_next     = 1'b0;
          addr_next     = cur_addr;
          wdata_next    = wr_data;
          cur_addr_next = cur_addr + ADDR_W'(1);
          beats_next    = beats - BEAT_W'(1);
          if (beats == BEAT_W'(1)) state_next = S_DONE;
        end
      end
      S_READ: begin
        if (credit_ok) begin
          ce_n_next     = 1'b0;
          addr_next     = cur_addr;
          cur_addr_next = cur_addr + ADDR_W'(1);
          beats_next    = beats - BEAT_W'(1);
          if (beats == BEAT_W'(1)) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outstanding == '0 && count == '0) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      beats      <= '0;
      err        <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      tag        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_next;
      cur_addr   <= cur_addr_next;
      beats      <= beats_next;
      err        <= err_next;
      sram_ce_n  <= ce_n_next;
      sram_we_n  <= we_n_next;
      sram_addr  <= addr_next;
      sram_wdata <= wdata_next;
      tag        <= tag_next;
      if (push) wr_ptr <= (wr_ptr == PTR_W'(BUF_D - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(BUF_D - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Buffer storage needs no reset: the occupancy count alone decides what is valid.
  always_ff @(posedge ACLK) begin
    if (push) buf_mem[wr_ptr] <= sram_rdata;
  end

endmodule

// File: tb/tb_sram_cmd_sequencer.sv
// Directed bench for sram_cmd_sequencer: four instances (RD_LAT 1..4) share one stimulus stream,
// each with its own behavioural SRAM; lane 0 is additionally checked at the SRAM pins.
module tb_sram_cmd_sequencer;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int NL     = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_rnw = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_ready = 1'b0;

  logic [NL-1:0] cmd_ready_v, wr_ready_v, rd_valid_v, done_v, err_v, ce_n_v, we_n_v;
  logic [NL-1:0][ADDR_W-1:0] addr_v;
  logic [NL-1:0][DATA_W-1:0] wdata_v, rdata_v, rd_data_v;
  logic [NL-1:0][15:0]       rd_issued_v, wr_cnt_v;

  logic [DATA_W-1:0] shadow [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      logic [DATA_W-1:0] mem  [DEPTH];
      logic [DATA_W-1:0] pipe [gi+1];
      logic [15:0]       rd_issued = '0;
      logic [15:0]       wr_cnt = '0;

      sram_cmd_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(gi + 1)
      ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_v[gi]), .cmd_rnw(cmd_rnw),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready_v[gi]), .wr_data(wr_data),
        .rd_valid(rd_valid_v[gi]), .rd_ready(rd_ready), .rd_data(rd_data_v[gi]),
        .done(done_v[gi]), .err(err_v[gi]),
        .sram_ce_n(ce_n_v[gi]), .sram_we_n(we_n_v[gi]), .sram_addr(addr_v[gi]),
        .sram_wdata(wdata_v[gi]), .sram_rdata(rdata_v[gi])
      );

      // SRAM model: data read at edge t is on sram_rdata after edge t+RD_LAT-1.
      always @(posedge ACLK) begin
        if (cmd_valid && cmd_ready_v[gi]) begin
          rd_issued <= '0;
          wr_cnt    <= '0;
        end
        if (!ce_n_v[gi]) begin
          if (!we_n_v[gi]) begin
            mem[addr_v[gi]] <= wdata_v[gi];
            wr_cnt <= wr_cnt + 16'd1;
          end else begin
            pipe[0]   <= mem[addr_v[gi]];
            rd_issued <= rd_issued + 16'd1;
          end
        end
        for (int i = 1; i <= gi; i++) pipe[i] <= pipe[i-1];
      end
      assign rdata_v[gi]     = pipe[gi];
      assign rd_issued_v[gi] = rd_issued;
      assign wr_cnt_v[gi]    = wr_cnt;
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic bit out_of_range(input int addr, input int len);
    bit rej;
    rej = 1'b0;
`ifdef SRAM_SEQ_BOUNDS_CHECK_EN
    rej = (addr + len) > (DEPTH - 1);
`endif
    return rej;
  endfunction

  task automatic send_cmd(input logic rnw, input int addr, input int len);
    int n;
    bit rej;
    n   = 0;
    rej = out_of_range(addr, len);
    $display("cmd %s addr=%0d len=%0d", rnw ? "read" : "write", addr, len);
    while (cmd_ready_v != 4'hF && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_idle", 32'(cmd_ready_v), 32'hF);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = LEN_W'(len);
    tick();
    cmd_valid = 1'b0;
    check("cmd_ready_busy", 32'(cmd_ready_v), 32'h0);
    check("err_after_accept", 32'(err_v), rej ? 32'hF : 32'h0);
    check("done_after_accept", 32'(done_v), rej ? 32'hF : 32'h0);
  endtask

  task automatic write_burst(input int addr, input int len, input logic [31:0] base, input bit gaps);
    int a;
    send_cmd(1'b0, addr, len);
    if (out_of_range(addr, len)) begin
      check("rej_wr_ready", 32'(wr_ready_v), 32'h0);
      check("rej_ce_n", 32'(ce_n_v), 32'hF);
      tick();
      check("rej_err_sticky", 32'(err_v), 32'hF);
      check("rej_ce_n_idle", 32'(ce_n_v), 32'hF);
      check("rej_done_low", 32'(done_v), 32'h0);
      check("rej_no_write", 32'(wr_cnt_v[0]), 32'h0);
      return;
    end
    for (int b = 0; b <= len; b++) begin
      a = (addr + b) % DEPTH;
      if (gaps && b > 0) begin
        wr_valid = 1'b0;
        tick();
        check("gap_ce_n", 32'(ce_n_v[0]), 32'h1);
      end
      check("wr_ready", 32'(wr_ready_v), 32'hF);
      wr_valid = 1'b1;
      wr_data  = base + 32'(b);
      tick();
      check("wr_ce_n", 32'(ce_n_v[0]), 32'h0);
      check("wr_we_n", 32'(we_n_v[0]), 32'h0);
      check("wr_addr", 32'(addr_v[0]), 32'(a));
      check("wr_wdata", wdata_v[0], base + 32'(b));
      shadow[a] = base + 32'(b);
    end
    wr_valid = 1'b0;
    check("wr_done", 32'(done_v), 32'hF);
    tick();
    check("wr_done_one_cycle", 32'(done_v), 32'h0);
    check("wr_ce_n_idle", 32'(ce_n_v), 32'hF);
    check("wr_count", 32'(wr_cnt_v[0]), 32'(len + 1));
    check("wr_err", 32'(err_v), 32'h0);
  endtask

  task automatic read_burst(input int addr, input int len, input int stall);
    int idx [NL];
    bit fin [NL];
    bit all_fin;
    int n;
    rd_ready = (stall == 0);
    send_cmd(1'b1, addr, len);
    if (stall > 0) begin
      repeat (stall) tick();
      for (int k = 0; k < NL; k++) begin
        check($sformatf("credit_fill_l%0d", k), 32'(rd_issued_v[k]), 32'(k + 3));
        check($sformatf("stall_rd_valid_l%0d", k), 32'(rd_valid_v[k]), 32'h1);
      end
      repeat (3) tick();
      for (int k = 0; k < NL; k++)
        check($sformatf("credit_hold_l%0d", k), 32'(rd_issued_v[k]), 32'(k + 3));
      rd_ready = 1'b1;
    end
    for (int k = 0; k < NL; k++) begin
      idx[k] = 0;
      fin[k] = 1'b0;
    end
    all_fin = 1'b0;
    n = 0;
    while (!all_fin && n < 400) begin
      all_fin = 1'b1;
      for (int k = 0; k < NL; k++) begin
        if (rd_valid_v[k]) begin
          check($sformatf("rd_data_l%0d_b%0d", k, idx[k]), rd_data_v[k],
                shadow[(addr + idx[k]) % DEPTH]);
          idx[k]++;
        end
        if (done_v[k]) begin
          check($sformatf("rd_beats_at_done_l%0d", k), 32'(idx[k]), 32'(len + 1));
          fin[k] = 1'b1;
        end
        if (!fin[k]) all_fin = 1'b0;
      end
      tick();
      n++;
    end
    check("rd_all_done", 32'(all_fin), 32'h1);
    check("rd_done_one_cycle", 32'(done_v), 32'h0);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_ce_n", 32'(ce_n_v), 32'hF);
    check("rst_we_n", 32'(we_n_v), 32'hF);
    check("rst_rd_valid", 32'(rd_valid_v), 32'h0);
    check("rst_done_err", 32'({done_v, err_v}), 32'h0);
    check("rst_sram_addr", 32'(addr_v[0]), 32'h0);
    check("rst_rd_data", rd_data_v[0], 32'h0);
    ARESETN = 1'b1;
    tick();
    check("rst_cmd_ready", 32'(cmd_ready_v), 32'hF);
    check("rst_wr_ready", 32'(wr_ready_v), 32'h0);

    write_burst(0, 3, 32'd1, 1'b0);
    read_burst(0, 3, 0);

    write_burst(16, 15, 32'h100, 1'b0);
    read_burst(16, 15, 12);

    write_burst(DEPTH - 2, 3, 32'h200, 1'b0);
    if (!out_of_range(DEPTH - 2, 3)) read_burst(DEPTH - 2, 3, 0);

    // Reset in the middle of an 8-beat read.
    rd_ready = 1'b1;
    send_cmd(1'b1, 16, 7);
    repeat (4) tick();
    ARESETN = 1'b0;
    #1;
    check("mid_rst_rd_valid", 32'(rd_valid_v), 32'h0);
    check("mid_rst_ce_n", 32'(ce_n_v), 32'hF);
    check("mid_rst_we_n", 32'(we_n_v), 32'hF);
    check("mid_rst_done_err", 32'({done_v, err_v}), 32'h0);
    check("mid_rst_sram_addr", 32'(addr_v[0]), 32'h0);
    check("mid_rst_sram_wdata", wdata_v[0], 32'h0);
    check("mid_rst_rd_data", rd_data_v[0], 32'h0);
    repeat (2) tick();
    ARESETN = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("post_rst_cmd_ready", 32'(cmd_ready_v), 32'hF);
      check("post_rst_no_done", 32'(done_v), 32'h0);
      check("post_rst_rd_valid", 32'(rd_valid_v), 32'h0);
    end
    read_burst(0, 3, 0);

    write_burst(40, 1, 32'h300, 1'b1);
    read_burst(40, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
